// File: rtl/branch_record_pkg.sv
// Shared types and defaults for the branch recorder: record layout plus default sizing.
package branch_record_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 17;
    localparam int unsigned DEFAULT_DEPTH      = 8;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] address;
        logic                          take;
    } branch_record_t;

endpackage

// File: rtl/branch_record_fifo.sv
// Two-write / one-read circular buffer for branch records; slot 0 is written before slot 1
// and the two writes are compacted onto consecutive entries.
module branch_record_fifo
    import branch_record_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_ADDR_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [WIDTH-1:0]         wr0_data,
    input  logic                     wr1_en,
    input  logic [WIDTH-1:0]         wr1_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW-1:0]    tail1;
    logic [PW:0]      count_q;
    logic [1:0]       n_wr;

    // Slot 1 lands right after slot 0 when both write, else directly at the tail.
    assign tail1 = wr0_en ? tail_q + PW'(1) : tail_q;
    assign n_wr  = {1'b0, wr0_en} + {1'b0, wr1_en};

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_q[tail_q] <= wr0_data;
        end
        if (wr1_en) begin
            mem_q[tail1] <= wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_q + PW'(n_wr);
            head_q  <= head_q + PW'(pop);
            count_q <= count_q + (PW+1)'(n_wr) - (PW+1)'(pop);
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/branch_recorder.sv
// Commit-side producer for the branch predictor update port; drains one record per cycle.
// Optional performance counters are built when BRANCH_STATS_EN is defined.
module branch_recorder
    import branch_record_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit0_en,
    input  logic [ADDR_WIDTH-1:0] commit0_address,
    input  logic                  commit0_take,
    input  logic                  commit0_pred,
    input  logic                  commit1_en,
    input  logic [ADDR_WIDTH-1:0] commit1_address,
    input  logic                  commit1_take,
    input  logic                  commit1_pred,
    output logic                  full,
    output logic                  branch_record_en,
    output logic [ADDR_WIDTH-1:0] branch_address,
    output logic                  branch_take,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]       count;
    logic [ADDR_WIDTH:0] head_data;
    logic                wr0;
    logic                wr1;
    logic                pop;
    logic                record_en_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic                take_q;

    // All-or-nothing acceptance: a full queue drops both slots.
    assign full = count > CW'(DEPTH - 2);
    assign wr0  = commit0_en & ~full;
    assign wr1  = commit1_en & ~full;
    assign pop  = count != '0;

    branch_record_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr0_en    (wr0),
        .wr0_data  ({commit0_address, commit0_take}),
        .wr1_en    (wr1),
        .wr1_data  ({commit1_address, commit1_take}),
        .pop       (pop),
        .count     (count),
        .head_data (head_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            record_en_q <= 1'b0;
            address_q   <= '0;
            take_q      <= 1'b0;
        end else begin
            record_en_q <= pop;
            if (pop) begin
                address_q <= head_data[ADDR_WIDTH:1];
                take_q    <= head_data[0];
            end
        end
    end

    assign branch_record_en = record_en_q;
    assign branch_address   = address_q;
    assign branch_take      = take_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;
    logic        mis0;
    logic        mis1;

    assign mis0 = wr0 & (commit0_take ^ commit0_pred);
    assign mis1 = wr1 & (commit1_take ^ commit1_pred);

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_q + 32'(wr0) + 32'(wr1);
            mispredict_count_q <= mispredict_count_q + 32'(mis0) + 32'(mis1);
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    logic unused_pred;

    assign unused_pred      = commit0_pred ^ commit1_pred;
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_recorder.sv
// Self-checking bench for branch_recorder against a queue-based reference model.
module tb_branch_recorder;
    import branch_record_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 17;

    logic          clk;
    logic          rst;
    logic          commit0_en, commit0_take, commit0_pred;
    logic [AW-1:0] commit0_address;
    logic          commit1_en, commit1_take, commit1_pred;
    logic [AW-1:0] commit1_address;
    logic          full;
    logic          branch_record_en;
    logic [AW-1:0] branch_address;
    logic          branch_take;
    logic [31:0]   branch_count;
    logic [31:0]   mispredict_count;

    branch_recorder #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .commit0_en       (commit0_en),
        .commit0_address  (commit0_address),
        .commit0_take     (commit0_take),
        .commit0_pred     (commit0_pred),
        .commit1_en       (commit1_en),
        .commit1_address  (commit1_address),
        .commit1_take     (commit1_take),
        .commit1_pred     (commit1_pred),
        .full             (full),
        .branch_record_en (branch_record_en),
        .branch_address   (branch_address),
        .branch_take      (branch_take),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             vectors;
    int             miscompares;
    int             cyc;
    int             records_seen;
    bit             saw_full;
    branch_record_t model_q[$];
    logic           exp_en;
    logic [AW-1:0]  exp_addr;
    logic           exp_take;
    logic           exp_full;
    logic [31:0]    exp_bc;
    logic [31:0]    exp_mc;

    // One clock: drive inputs, advance the model by the queue rules, then sample #1 after the edge.
    task automatic cycle(input logic r,
                         input logic e0, input logic [AW-1:0] a0, input logic t0, input logic p0,
                         input logic e1, input logic [AW-1:0] a1, input logic t1, input logic p1);
        bit             accept;
        branch_record_t rec;
        rst = r;
        commit0_en = e0; commit0_address = a0; commit0_take = t0; commit0_pred = p0;
        commit1_en = e1; commit1_address = a1; commit1_take = t1; commit1_pred = p1;
        accept = model_q.size() <= int'(DEPTH) - 2;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            exp_en = 1'b0; exp_addr = '0; exp_take = 1'b0; exp_bc = '0; exp_mc = '0;
        end else begin
            exp_en = model_q.size() != 0;
            if (exp_en) begin
                rec      = model_q.pop_front();
                exp_addr = rec.address;
                exp_take = rec.take;
            end
            if (accept) begin
                if (e0) model_q.push_back('{address: a0, take: t0});
                if (e1) model_q.push_back('{address: a1, take: t1});
`ifdef BRANCH_STATS_EN
                exp_bc += 32'(e0) + 32'(e1);
                exp_mc += 32'(e0 && (t0 != p0)) + 32'(e1 && (t1 != p1));
`endif
            end
        end
        exp_full = model_q.size() > int'(DEPTH) - 2;
        #1;
        cyc++;
        records_seen += int'(branch_record_en);
        if (full) saw_full = 1'b1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 17'h0abcd, 1'b1, 1'b0, 1'b1, 17'h00111, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle();
            vectors++;
            if ({branch_record_en, branch_address, branch_take, full, branch_count,
                 mispredict_count} !== 52'd0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got en=%b addr=%h take=%b full=%b bc=%0d mc=%0d, want all zero",
                         cyc, branch_record_en, branch_address, branch_take, full,
                         branch_count, mispredict_count);
            end
        end
    endtask

    task automatic test_single();
        int start;
        int hit_cycle;
        start = records_seen;
        hit_cycle = -1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) cycle(1'b0, 1'b1, 17'h01234, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            else        idle();
            if (branch_record_en) hit_cycle = i;
            vectors++;
            if ({branch_record_en, branch_address, branch_take, full, branch_count,
                 mispredict_count} !== {exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc}) begin
                miscompares++;
                $display("FAIL single cycle %0d: got en=%b addr=%h take=%b full=%b bc=%0d mc=%0d, want en=%b addr=%h take=%b full=%b bc=%0d mc=%0d",
                         cyc, branch_record_en, branch_address, branch_take, full, branch_count,
                         mispredict_count, exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc);
            end
        end
        // Commit sampled at edge 0; record is visible after edge 1 (two cycles after presenting).
        vectors++;
        if (records_seen - start != 1 || hit_cycle != 1) begin
            miscompares++;
            $display("FAIL single_latency: got %0d records last at step %0d, want 1 record at step 1",
                     records_seen - start, hit_cycle);
        end
    endtask

    task automatic test_slot1_only();
        int start;
        start = records_seen;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) cycle(1'b0, 1'b0, 17'h00055, 1'b1, 1'b1, 1'b1, 17'h1ffff, 1'b0, 1'b1);
            else        idle();
            vectors++;
            if ({branch_record_en, branch_address, branch_take, full, branch_count,
                 mispredict_count} !== {exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc}) begin
                miscompares++;
                $display("FAIL slot1_only cycle %0d: got en=%b addr=%h take=%b full=%b bc=%0d mc=%0d, want en=%b addr=%h take=%b full=%b bc=%0d mc=%0d",
                         cyc, branch_record_en, branch_address, branch_take, full, branch_count,
                         mispredict_count, exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc);
            end
        end
        vectors++;
        if (records_seen - start != 1) begin
            miscompares++;
            $display("FAIL slot1_only_count: got %0d records, want 1", records_seen - start);
        end
    endtask

    task automatic test_dual_burst();
        saw_full = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (i < 16) cycle(1'b0, 1'b1, AW'($urandom), 1'($urandom), 1'($urandom),
                              1'b1, AW'($urandom), 1'($urandom), 1'($urandom));
            else        idle();
            vectors++;
            if ({branch_record_en, branch_address, branch_take, full, branch_count,
                 mispredict_count} !== {exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc}) begin
                miscompares++;
                $display("FAIL dual_burst cycle %0d: got en=%b addr=%h take=%b full=%b bc=%0d mc=%0d, want en=%b addr=%h take=%b full=%b bc=%0d mc=%0d",
                         cyc, branch_record_en, branch_address, branch_take, full, branch_count,
                         mispredict_count, exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc);
            end
        end
        vectors++;
        if (saw_full !== 1'b1) begin
            miscompares++;
            $display("FAIL dual_burst_full: got full seen=%b, want 1", saw_full);
        end
    endtask

    task automatic test_wrap();
        int start;
        start = records_seen;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) cycle(1'b0, 1'b1, AW'($urandom), 1'(i % 2), 1'($urandom),
                              1'b0, '0, 1'b0, 1'b0);
            else        idle();
            vectors++;
            if ({branch_record_en, branch_address, branch_take, full, branch_count,
                 mispredict_count} !== {exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc}) begin
                miscompares++;
                $display("FAIL wrap cycle %0d: got en=%b addr=%h take=%b full=%b bc=%0d mc=%0d, want en=%b addr=%h take=%b full=%b bc=%0d mc=%0d",
                         cyc, branch_record_en, branch_address, branch_take, full, branch_count,
                         mispredict_count, exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc);
            end
        end
        vectors++;
        if (records_seen - start != 20 || branch_record_en !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_drain: got %0d records en=%b, want 20 records en=0",
                     records_seen - start, branch_record_en);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, AW'($urandom), 1'($urandom), 1'($urandom),
                  1'b1, AW'($urandom), 1'($urandom), 1'($urandom));
        end
        vectors++;
        if (model_q.size() != 5) begin
            miscompares++;
            $display("FAIL reset_mid_fill: got model depth %0d, want 5", model_q.size());
        end
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) idle();
            vectors++;
            if ({branch_record_en, branch_address, branch_take, full, branch_count,
                 mispredict_count} !== 52'd0) begin
                miscompares++;
                $display("FAIL reset_mid cycle %0d: got en=%b addr=%h take=%b full=%b bc=%0d mc=%0d, want all zero",
                         cyc, branch_record_en, branch_address, branch_take, full,
                         branch_count, mispredict_count);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 99) < 60), AW'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 99) < 50), AW'($urandom), 1'($urandom), 1'($urandom));
            vectors++;
            if ({branch_record_en, branch_address, branch_take, full, branch_count,
                 mispredict_count} !== {exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc}) begin
                miscompares++;
                $display("FAIL random cycle %0d: got en=%b addr=%h take=%b full=%b bc=%0d mc=%0d, want en=%b addr=%h take=%b full=%b bc=%0d mc=%0d",
                         cyc, branch_record_en, branch_address, branch_take, full, branch_count,
                         mispredict_count, exp_en, exp_addr, exp_take, exp_full, exp_bc, exp_mc);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; records_seen = 0; saw_full = 1'b0;
        exp_en = 1'b0; exp_addr = '0; exp_take = 1'b0; exp_full = 1'b0; exp_bc = '0; exp_mc = '0;
        rst = 1'b1;
        commit0_en = 1'b0; commit0_address = '0; commit0_take = 1'b0; commit0_pred = 1'b0;
        commit1_en = 1'b0; commit1_address = '0; commit1_take = 1'b0; commit1_pred = 1'b0;
        test_reset();
        test_single();
        test_slot1_only();
        test_dual_burst();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_recorder.md
# branch_recorder

Commit-side producer for the branch predictor's update port. Accepts up to two resolved branches per cycle from the dual-wide commit stage, buffers them in order, and drains exactly one record per cycle onto the predictor's `branch_record_en` / `branch_address` / `branch_take` inputs. Optionally keeps branch and misprediction counters for performance tuning.

## Interface
- `DEPTH`, 8, queue entries; power of two, ≥ 4.
- `ADDR_WIDTH`, 17, branch instruction address width; matches the predictor.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `commit0_en`  in  1  older committed branch valid this cycle.
- `commit0_address`  in  ADDR_WIDTH  address of the older branch.
- `commit0_take`  in  1  actual outcome of the older branch.
- `commit0_pred`  in  1  outcome predicted at fetch for the older branch.
- `commit1_en`, `commit1_address`, `commit1_take`, `commit1_pred`: same fields for the younger branch.
- `full`  out  1  fewer than 2 free entries; the commit stage must not retire branches.
- `branch_record_en`  out  1  registered; the predictor record is valid this cycle.
- `branch_address`  out  ADDR_WIDTH  registered record address.
- `branch_take`  out  1  registered record outcome.
- `branch_count`  out  32  accepted branches; 0 without `BRANCH_STATS_EN`.
- `mispredict_count`  out  32  accepted branches with take ≠ pred; 0 without `BRANCH_STATS_EN`.

## Operation
- The circular buffer holds {address, take}. It has head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Write: enabled commit slots are written in order. Slot 0 goes first, then slot 1, compacted.
  - If only `commit1_en` is set, slot 1 is written to the tail.
  - Tail advances by the number of accepted writes (0, 1 or 2).
- `full` = (count > DEPTH−2), combinational from the current count.
  - Commits presented while `full` is 1 are discarded. They are not written and not counted.
  - Partial acceptance never occurs.
- Drain: at every posedge with count ≠ 0 (pre-edge value):
  - the head entry loads into the output registers;
  - `branch_record_en` <= 1;
  - head advances.
  - Otherwise `branch_record_en` <= 0, and address/take hold their last values.
- Simultaneous write and drain: count_next = count + writes − (count ≠ 0). A write into an empty queue is not drained in the same edge.
- The predictor never stalls. Drain rate is exactly 1 per cycle while the queue is non-empty.
- Order: records reach the predictor in commit order, with slot 0 before slot 1 within a cycle. The predictor's global history depends on this.
- Reset: queue emptied, pointers and count at 0, `branch_record_en` 0, `branch_address` 0, `branch_take` 0, `full` 0, counters 0. Reset mid-operation drops all buffered records without draining them.

## Timing
- Commit presented in cycle N to an empty queue: the entry is stored at the end of N, and `branch_record_en` is high in cycle N+2.
- A two-branch commit in cycle N to an empty queue produces records in cycles N+2 and N+3.
- `full` reflects writes and drains from the previous edge only. There is no same-cycle bypass.
- Counters update at the same edge that accepts the writes. They wrap modulo 2^32.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `branch_count` increments by the number of accepted commits.
  - `mispredict_count` increments by the number of accepted commits with `commitX_take != commitX_pred`. It can rise by 0, 1 or 2 per cycle.
- `BRANCH_STATS_EN` undefined:
  - counter registers are not built;
  - both count outputs are tied to 0;
  - the `commitX_pred` inputs are ignored.

## Structure
- The shared package `branch_record_pkg` holds:
  - the `ADDR_WIDTH` default (17);
  - the `branch_record_t` struct {address, take};
  - the default `DEPTH`.
- Sub-module `branch_record_fifo`: a 2-write / 1-read circular buffer exposing count, head entry and pop. `branch_recorder` wraps it with the output registers, the `full` logic and the stats counters.

## Test plan
- Reset, then idle: every output is 0 in the first cycle after reset, `branch_record_en` stays 0, `full` stays 0.
- Single commit, slot 0, address 0x01234, take 1, pred 0, in cycle 5: `branch_record_en`=1 with address 0x01234 and take 1 in cycle 7 only. With stats, `branch_count`=1 and `mispredict_count`=1 from cycle 6.
- Dual commit every cycle (DEPTH 8): `full` rises once count reaches 7; commits presented while `full` are dropped. Drained records are in exact commit order with no gaps or duplicates, slot 0 before slot 1.
- Only `commit1_en` set, address 0x1FFFF, take 0: one record with address 0x1FFFF and take 0, two cycles later.
- Wrap-around: 20 single commits with alternating take, drained fully: output order matches input order across pointer wrap, and the queue returns to empty.
- `rst` asserted with 5 entries buffered: next cycle `branch_record_en`=0, count 0, counters 0. No stale records appear after reset is released.
